// File: rtl/freecpu_alu_pkg.sv
// Shared types and helpers for the serial multi-limb adder datapath.
package freecpu_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int LIMB_W = 8;

    // Limb counter width; a single-limb build still needs one bit.
    function automatic int cnt_width(input int limbs);
        return (limbs <= 1) ? 1 : $clog2(limbs);
    endfunction

endpackage

// File: rtl/multi_limb_add_sequencer_if.sv
// Request/response bundle between ALU issue, the serial adder and writeback.
interface multi_limb_add_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/multi_limb_add_sequencer_fast_adder_slice.sv
// 8-bit generate/propagate carry-lookahead adder slice.
// Purely combinational, zero latency; no handshake.
// Every carry is a flat sum-of-products of g/p/cin, no ripple chain.
module fast_adder_slice
    import freecpu_alu_pkg::*;
(
    input  logic              cin,
    input  logic [LIMB_W-1:0] a,
    input  logic [LIMB_W-1:0] b,
    output logic [LIMB_W-1:0] out,
    output logic              cout
);
    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [LIMB_W:0]   c;
    logic              acc;
    logic              term;

    assign g = a & b;
    assign p = a ^ b;

    // c[i] = cin&p[0..i-1] | OR_j ( g[j] & p[j+1..i-1] )
    always_comb begin
        c    = '0;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i <= LIMB_W; i++) begin
            acc = cin;
            for (int k = 0; k < i; k++) begin
                acc = acc & p[k];
            end
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i] = acc;
        end
    end

    assign out  = p ^ c[LIMB_W-1:0];
    assign cout = c[LIMB_W];
endmodule

// File: rtl/multi_limb_add_sequencer.sv
// Serial WIDTH-bit adder: one 8-bit lookahead slice per cycle, carry registered between limbs.
// Latency: accept -> out_valid after WIDTH/8 RUN cycles; one op per WIDTH/8+2 cycles at best.
// Backpressure: in_ready low while busy; result held in DONE until out_ready. FREECPU_SUBTRACT_EN adds op=1 (a + ~b + cin).
module multi_limb_add_sequencer
    import freecpu_alu_pkg::*;
#(
    parameter int WIDTH = 32
)(
    input  logic                       clk,
    input  logic                       rst,
    multi_limb_add_sequencer_if.slave  bus
);
    localparam int              LIMBS = WIDTH / LIMB_W;
    localparam int              CW    = cnt_width(LIMBS);
    localparam logic [CW-1:0]   LAST  = CW'(LIMBS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              carry;
    logic              in_ready_q;
    logic              out_valid_q;
    logic              busy_q;
    logic              cout_q;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH-1:0]  sum_q;
    logic [LIMB_W-1:0] a_limb;
    logic [LIMB_W-1:0] b_limb;
    logic [LIMB_W-1:0] slice_sum;
    logic              slice_co;
    logic              accept;

    assign accept = (state == IDLE) && bus.in_valid && in_ready_q;

`ifdef FREECPU_SUBTRACT_EN
    logic op_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg <= 1'b0;
        end else if (accept) begin
            op_reg <= bus.op;
        end
    end

    assign b_eff = op_reg ? ~b_reg : b_reg;
`else
    logic unused_op;
    assign unused_op = bus.op;
    assign b_eff     = b_reg;
`endif

    assign a_limb = a_reg[cnt*LIMB_W +: LIMB_W];
    assign b_limb = b_eff[cnt*LIMB_W +: LIMB_W];

    fast_adder_slice u_slice (
        .cin  (carry),
        .a    (a_limb),
        .b    (b_limb),
        .out  (slice_sum),
        .cout (slice_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            cnt         <= '0;
            carry       <= 1'b0;
            a_reg       <= '0;
            b_reg       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg      <= bus.a;
                        b_reg      <= bus.b;
                        carry      <= bus.cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Untouched upper limbs keep whatever the previous result left there.
                    sum_q[cnt*LIMB_W +: LIMB_W] <= slice_sum;
                    carry <= slice_co;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout_q      <= slice_co;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: tb/tb_multi_limb_add_sequencer.sv
// Bench for multi_limb_add_sequencer: 32-bit and 8-bit instances, vector tables,
// hand-written handshake/reset sequences and randomized ops against an arithmetic model.
module tb_multi_limb_add_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    multi_limb_add_sequencer_if #(.WIDTH(32)) ifc ();
    multi_limb_add_sequencer_if #(.WIDTH(8))  ifc8 ();

    multi_limb_add_sequencer #(.WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    multi_limb_add_sequencer #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (ifc8.slave)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        op;
        logic [31:0] sum;
        logic        cout;
    } vec_t;

    vec_t v32[8];
    vec_t v8[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // Reference: plain integer arithmetic, {cout, sum} = a + b_eff + cin over w bits.
    function automatic logic [63:0] model(input int w, input logic [31:0] a_i,
                                          input logic [31:0] b_i, input logic ci, input logic o);
        logic [63:0] mask;
        logic [63:0] be;
        mask = (64'd1 << w) - 64'd1;
        be   = {32'd0, b_i} & mask;
`ifdef FREECPU_SUBTRACT_EN
        if (o) be = ~be & mask;
`else
        if (o) be = be;
`endif
        return ({32'd0, a_i} & mask) + be + {63'd0, ci};
    endfunction

    task automatic run32(input logic [31:0] a_i, input logic [31:0] b_i, input logic ci,
                         input logic o, input int stall,
                         output logic [31:0] s, output logic co, output int lat);
        int guard;
        @(negedge clk);
        ifc.a = a_i; ifc.b = b_i; ifc.cin = ci; ifc.op = o;
        ifc.in_valid = 1'b1;
        ifc.out_ready = (stall == 0);
        guard = 0;
        while (!ifc.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ifc.in_ready) timeout_fail("accept32");
        @(negedge clk);
        ifc.in_valid = 1'b0;
        lat = 1;
        while (!ifc.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!ifc.out_valid) timeout_fail("result32");
        repeat (stall) @(negedge clk);
        s = ifc.sum;
        co = ifc.cout;
        ifc.out_ready = 1'b1;
    endtask

    task automatic run8(input logic [7:0] a_i, input logic [7:0] b_i, input logic ci,
                        input logic o, output logic [7:0] s, output logic co, output int lat);
        int guard;
        @(negedge clk);
        ifc8.a = a_i; ifc8.b = b_i; ifc8.cin = ci; ifc8.op = o;
        ifc8.in_valid = 1'b1;
        ifc8.out_ready = 1'b1;
        guard = 0;
        while (!ifc8.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ifc8.in_ready) timeout_fail("accept8");
        @(negedge clk);
        ifc8.in_valid = 1'b0;
        lat = 1;
        while (!ifc8.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!ifc8.out_valid) timeout_fail("result8");
        s = ifc8.sum;
        co = ifc8.cout;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        logic [7:0]  s8;
        logic        co;
        int          lat;
        int          bad;
        int          guard;
        logic [63:0] r;
        logic [31:0] ra, rb;
        logic        rc, ro;

        v32[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1};
        v32[1] = '{32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b0, 32'hACF13569, 1'b0};
        v32[2] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
        v32[3] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1};
        v32[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1};
        v32[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0};
`ifdef FREECPU_SUBTRACT_EN
        v32[6] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0};
        v32[7] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1};
        v8[3]  = '{32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0};
`else
        v32[6] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'h0000000D, 1'b0};
        v32[7] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h0000000D, 1'b0};
        v8[3]  = '{32'h05, 32'h07, 1'b1, 1'b1, 32'h0D, 1'b0};
`endif
        v8[0] = '{32'h80, 32'h80, 1'b1, 1'b0, 32'h01, 1'b1};
        v8[1] = '{32'hFF, 32'h01, 1'b0, 1'b0, 32'h00, 1'b1};
        v8[2] = '{32'h0F, 32'h01, 1'b0, 1'b0, 32'h10, 1'b0};

        rst = 1'b1;
        ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
        ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0; ifc.op = 1'b0;
        ifc8.in_valid = 1'b0; ifc8.out_ready = 1'b0;
        ifc8.a = '0; ifc8.b = '0; ifc8.cin = 1'b0; ifc8.op = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_in_ready",  ifc.in_ready, 1);
        chk("reset_out_valid", ifc.out_valid, 0);
        chk("reset_busy",      ifc.busy, 0);
        chk("reset_sum",       ifc.sum, 0);
        chk("reset_cout",      ifc.cout, 0);
        chk("reset8_in_ready", ifc8.in_ready, 1);
        chk("reset8_sum",      ifc8.sum, 0);

        for (int i = 0; i < 8; i++) begin
            run32(v32[i].a, v32[i].b, v32[i].cin, v32[i].op, 0, s, co, lat);
            chk($sformatf("vec32_%0d_sum", i), s, v32[i].sum);
            chk($sformatf("vec32_%0d_cout", i), co, v32[i].cout);
            chk($sformatf("vec32_%0d_latency", i), lat, 5);
        end

        // Stall in DONE with a second request already pending.
        @(negedge clk);
        ifc.a = 32'h11111111; ifc.b = 32'h22222222; ifc.cin = 1'b0; ifc.op = 1'b0;
        ifc.in_valid = 1'b1; ifc.out_ready = 1'b0;
        guard = 0;
        while (!ifc.in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!ifc.in_ready) timeout_fail("hold_accept");
        @(negedge clk);
        ifc.a = 32'h00001000; ifc.b = 32'h00000234;
        bad = 0; guard = 0;
        while (!ifc.out_valid && guard < 50) begin
            if (ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) bad++;
            @(negedge clk);
            guard++;
        end
        if (!ifc.out_valid) timeout_fail("hold_result");
        chk("run_flags", bad, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (ifc.out_valid !== 1'b1 || ifc.sum !== 32'h33333333 ||
                ifc.cout !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("done_hold_stable", bad, 0);
        chk("done_hold_sum", ifc.sum, 32'h33333333);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("release_out_valid", ifc.out_valid, 0);
        chk("release_in_ready", ifc.in_ready, 1);
        @(negedge clk);
        chk("second_accept_busy", ifc.busy, 1);
        chk("second_accept_in_ready", ifc.in_ready, 0);
        ifc.in_valid = 1'b0;
        guard = 0;
        while (!ifc.out_valid && guard < 50) begin @(negedge clk); guard++; end
        if (!ifc.out_valid) timeout_fail("second_result");
        chk("second_sum", ifc.sum, 32'h00001234);
        chk("second_cout", ifc.cout, 0);

        // Reset two limbs into RUN.
        @(negedge clk);
        ifc.a = 32'h11111111; ifc.b = 32'h11111111; ifc.cin = 1'b0; ifc.op = 1'b0;
        ifc.in_valid = 1'b1;
        guard = 0;
        while (!ifc.in_ready && guard < 50) begin @(negedge clk); guard++; end
        if (!ifc.in_ready) timeout_fail("rst_accept");
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("partial_sum", ifc.sum, 32'h00002222);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrun_rst_in_ready",  ifc.in_ready, 1);
        chk("midrun_rst_out_valid", ifc.out_valid, 0);
        chk("midrun_rst_sum",       ifc.sum, 0);
        chk("midrun_rst_cout",      ifc.cout, 0);
        chk("midrun_rst_busy",      ifc.busy, 0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (ifc.out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("midrun_rst_no_result", bad, 0);
        run32(32'd5, 32'd3, 1'b0, 1'b0, 0, s, co, lat);
        chk("after_rst_sum", s, 32'd8);
        chk("after_rst_cout", co, 0);

        for (int i = 0; i < 4; i++) begin
            run8(v8[i].a[7:0], v8[i].b[7:0], v8[i].cin, v8[i].op, s8, co, lat);
            chk($sformatf("vec8_%0d_sum", i), s8, v8[i].sum[7:0]);
            chk($sformatf("vec8_%0d_cout", i), co, v8[i].cout);
            chk($sformatf("vec8_%0d_latency", i), lat, 2);
        end

        for (int i = 0; i < 150; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            run32(ra, rb, rc, ro, int'($urandom_range(0, 3)), s, co, lat);
            r = model(32, ra, rb, rc, ro);
            chk($sformatf("rand32_%0d_sum", i), s, r[31:0]);
            chk($sformatf("rand32_%0d_cout", i), co, r[32]);
            chk($sformatf("rand32_%0d_latency", i), lat, 5);
        end

        for (int i = 0; i < 50; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); ro = 1'($urandom_range(0, 1));
            run8(ra[7:0], rb[7:0], rc, ro, s8, co, lat);
            r = model(8, ra, rb, rc, ro);
            chk($sformatf("rand8_%0d_sum", i), s8, r[7:0]);
            chk($sformatf("rand8_%0d_cout", i), co, r[8]);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_limb_add_sequencer.md
Name: multi_limb_add_sequencer

Overview:
- Adds two WIDTH-bit operands serially, 8 bits per cycle, through one shared 8-bit carry-lookahead adder slice.
- Carry is registered between slices. Lets wide integer arithmetic in the CPU ALU reuse a single small fast adder instead of a full-width one.
- Sits between the ALU issue logic (request side) and the result writeback (response side).
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8 and at least 8.
- LIMBS, WIDTH/8, number of 8-bit slices; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready on a clock edge.
- a  input  WIDTH  operand A; sampled on accept.
- b  input  WIDTH  operand B; sampled on accept.
- cin  input  1  carry-in to limb 0; sampled on accept.
- op  input  1  0 = add, 1 = subtract. Sampled on accept. Ignored (treated as 0) without FREECPU_SUBTRACT_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  result consumed when out_valid && out_ready on a clock edge.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the most significant limb.
- busy  output  1  high in RUN or DONE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, limb counter=0, carry register=0, operand registers=0.
- IDLE:
  - in_ready=1.
  - On accept: latch a, b, cin (into the carry register) and op; counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, slice index k = counter. Feed a_reg[8k+7:8k], b_eff[8k+7:8k] and the carry register to the adder slice.
  - Write the slice sum into sum[8k+7:8k] and the slice carry-out into the carry register; counter++.
  - After limb LIMBS-1: cout = slice carry-out; go to DONE.
  - RUN lasts exactly LIMBS cycles.
- DONE:
  - out_valid=1; sum and cout stable.
  - On out_ready: out_valid=0, go to IDLE. New accept is possible the following cycle; no same-cycle turnaround.
- Latency: accept edge at cycle 0 → out_valid high from cycle LIMBS+1. Throughput is one operation per LIMBS+2 cycles when out_ready is held high.
- Output holding:
  - sum bits not yet written in RUN keep their previous values.
  - sum is only architecturally valid while out_valid=1.
  - out_valid must not drop without a handshake.
- in_valid while busy: ignored, not queued. The requester holds in_valid until in_ready.
- Arithmetic: slice computes {co, s} = x + y + ci over 8 bits, modulo 2^8 with carry out. Overall result = (a + b_eff + cin) mod 2^WIDTH, with cout the bit WIDTH carry.
- WIDTH=8 corner: RUN lasts exactly 1 cycle.
- rst asserted in any state, including mid-RUN: all state returns to reset values on that edge. The partial result is discarded and no out_valid is produced.

Optional Feature:
- Macro FREECPU_SUBTRACT_EN.
- Defined: b_eff = op ? ~b : b. Result = a + ~b + cin, so op=1 with cin=1 gives a - b. cout=1 means no borrow.
- Undefined: b_eff = b. The op port exists but is ignored, and no inversion logic is synthesized.

Decomposition:
- Shared package freecpu_alu_pkg:
  - state enum {IDLE, RUN, DONE} as a 2-bit typedef.
  - localparam LIMB_W=8.
  - function computing the counter width, $clog2(LIMBS) with a minimum of 1.
- One sub-module: fast_adder_slice. Purely combinational 8-bit generate/propagate carry-lookahead adder with ports cin, a[7:0], b[7:0], out[7:0], cout.
- Sequencing, handshake and registers stay in multi_limb_add_sequencer.

Test Plan:
1. WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0, op=0, out_ready=1 → out_valid first high 5 cycles after accept; sum=0x00000000, cout=1.
2. a=0x12345678, b=0x9ABCDEF0, cin=1 → sum=0xACF13569, cout=0; in_ready=0 and busy=1 from accept until the DONE handshake.
3. out_ready=0 for 10 cycles in DONE → out_valid stays 1, sum/cout stable, in_ready=0, a second in_valid is ignored. Raise out_ready → returns to IDLE, then the second request is accepted the next cycle.
4. rst pulsed 2 cycles into RUN → next cycle in_ready=1, out_valid=0, sum=0, cout=0. A following request a=5, b=3 yields sum=8.
5. With FREECPU_SUBTRACT_EN: op=1, cin=1, a=0x00000005, b=0x00000007 → sum=0xFFFFFFFE, cout=0. Without the macro, same stimulus → sum=0x0000000D, cout=0.
6. WIDTH=8 instance: a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, out_valid 2 cycles after accept.
